// File: rtl/dg0045_ram_arbiter.sv
// DG0045 data RAM (64x4) shared between the core datapath and a host debug port.
// The host gets a two-clock slot per 8-clock machine cycle; the core always has write priority.
module dg0045_ram_arbiter #(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned SLOT_PHASE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        core_phase,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_din,
   input  logic              core_we,
   output logic [DATA_W-1:0] core_dout,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_din,
   output logic              host_gnt,
   output logic              host_done,
   output logic [DATA_W-1:0] host_dout,
   output logic              host_busy,
   output logic [3:0]        conflict_cnt
);

   localparam int unsigned DEPTH    = 1 << ADDR_W;
   localparam logic [2:0]  SLOT_PRE = 3'((SLOT_PHASE + 7) % 8);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SLOT,
      ACC1,
      ACC2,
      DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   logic                h_we;
   logic [ADDR_W-1:0]   h_addr;
   logic [DATA_W-1:0]   h_din;

   logic [ADDR_W-1:0]   mux_addr;
   logic                latch_req;
   logic                conflict;
   logic                host_wr;
   logic                host_rd;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      host_gnt  = 1'b0;
      host_done = 1'b0;
      host_busy = 1'b1;
      latch_req = 1'b0;
      conflict  = 1'b0;
      case (state)
         IDLE: begin
            host_busy = 1'b0;
            if (host_req) begin
               latch_req = 1'b1;
               state_nxt = (core_phase == SLOT_PRE) ? ACC1 : WAIT_SLOT;
            end
         end
         WAIT_SLOT: begin
            if (core_phase == SLOT_PRE) state_nxt = ACC1;
         end
         ACC1, ACC2: begin
            host_gnt = 1'b1;
            // A core write anywhere in the slot aborts it; retry at the next slot.
            if (core_we) begin
               conflict  = 1'b1;
               state_nxt = WAIT_SLOT;
            end else begin
               state_nxt = (state == ACC1) ? ACC2 : DONE;
            end
         end
         DONE: begin
            host_done = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            host_busy = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign mux_addr  = host_gnt ? h_addr : core_addr;
   assign core_dout = mem[mux_addr];

   assign host_wr = (state == ACC1) &&  h_we && !core_we && !rst;
   assign host_rd = (state == ACC1) && !h_we && !core_we;

   // Core writes bypass the address mux so they land even during a host slot.
   always_ff @(posedge clk) begin
      if (core_we)      mem[core_addr] <= core_din;
      else if (host_wr) mem[h_addr]    <= h_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_we         <= 1'b0;
         h_addr       <= '0;
         h_din        <= '0;
         host_dout    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (latch_req) begin
            h_we   <= host_we;
            h_addr <= host_addr;
            h_din  <= host_din;
         end
         if (host_rd) host_dout <= mem[h_addr];
         if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Directed self-checking bench for dg0045_ram_arbiter with SLOT_PHASE = 0.
// The bench drives core_phase itself; inputs change 1 ns after posedge.
module tb_dg0045_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] core_phase;
   logic [5:0] core_addr;
   logic [3:0] core_din;
   logic       core_we;
   logic [3:0] core_dout;
   logic       host_req;
   logic       host_we;
   logic [5:0] host_addr;
   logic [3:0] host_din;
   logic       host_gnt;
   logic       host_done;
   logic [3:0] host_dout;
   logic       host_busy;
   logic [3:0] conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   dg0045_ram_arbiter #(
      .ADDR_W     (6),
      .DATA_W     (4),
      .SLOT_PHASE (0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .core_phase   (core_phase),
      .core_addr    (core_addr),
      .core_din     (core_din),
      .core_we      (core_we),
      .core_dout    (core_dout),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_din     (host_din),
      .host_gnt     (host_gnt),
      .host_done    (host_done),
      .host_dout    (host_dout),
      .host_busy    (host_busy),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      core_phase = core_phase + 3'd1;
   endtask

   task automatic wait_phase(input logic [2:0] p);
      for (int i = 0; i < 8; i++) begin
         if (core_phase == p) break;
         tick();
      end
   endtask

   // Counts clocks until host_done, noting slot phases and core_dout during the grant.
   task automatic wait_done(output int n, output logic [7:0] gmask, output logic [3:0] sdout);
      n     = 0;
      gmask = '0;
      sdout = '0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (host_gnt) begin
            gmask[core_phase] = 1'b1;
            sdout = core_dout;
         end
         if (host_done) break;
         tick();
         n++;
      end
   endtask

   task automatic host_op(input logic we, input logic [5:0] a, input logic [3:0] d,
                          output int lat, output logic [7:0] gmask, output logic [3:0] sdout);
      int n;
      host_req  = 1'b1;
      host_we   = we;
      host_addr = a;
      host_din  = d;
      tick();
      host_req = 1'b0;
      wait_done(n, gmask, sdout);
      lat = n + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         lat;
      int         n;
      int         nd;
      int         t [3];
      int         wins;
      logic [7:0] gm;
      logic [3:0] sd;
      logic       seen;
      logic       gnt_seen;
      logic [5:0] wa [24];
      logic [3:0] ref_mem [64];

      rst        = 1'b1;
      core_phase = 3'd0;
      core_addr  = '0;
      core_din   = '0;
      core_we    = 1'b0;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_din   = '0;
      tick();
      tick();
      check("rst_gnt",  host_gnt,     0);
      check("rst_done", host_done,    0);
      check("rst_busy", host_busy,    0);
      check("rst_dout", host_dout,    0);
      check("rst_cnt",  conflict_cnt, 0);
      rst = 1'b0;

      // Host write from phase 5.
      wait_phase(3'd5);
      check("wr_idle_busy", host_busy, 0);
      host_op(1'b1, 6'h2A, 4'h9, lat, gm, sd);
      check("wr_lat",   lat, 5);
      check("wr_gmask", gm, 8'h03);
      check("wr_phase", core_phase, 2);
      tick();
      core_addr = 6'h2A;
      #1;
      check("wr_core_dout", core_dout, 4'h9);

      // Core preload then host read at phase 7 (minimum latency).
      wait_phase(3'd6);
      core_addr = 6'h13;
      core_din  = 4'hC;
      core_we   = 1'b1;
      tick();
      core_we   = 1'b0;
      core_addr = 6'h2A;
      host_op(1'b0, 6'h13, 4'h0, lat, gm, sd);
      check("rd_lat",       lat, 3);
      check("rd_gmask",     gm, 8'h03);
      check("rd_slot_dout", sd, 4'hC);
      check("rd_host_dout", host_dout, 4'hC);
      tick();
      #1;
      check("rd_core_dout", core_dout, 4'h9);

      // Back-to-back reads with host_req held.
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 6'h13;
      nd = 0;
      t  = '{0, 0, 0};
      for (int c = 0; c <= 40; c++) begin
         #1;
         if (host_done) begin
            if (nd < 3) t[nd] = c;
            nd++;
            if (nd == 3) host_req = 1'b0;
         end
         tick();
      end
      host_req = 1'b0;
      check("b2b_count", nd, 3);
      check("b2b_first", t[0], 7);
      check("b2b_gap1",  t[1] - t[0], 8);
      check("b2b_gap2",  t[2] - t[1], 8);

      // Conflict: core writes 0x3 to 0x10 during the ACC1 of a host write of 0x5.
      wait_phase(3'd7);
      host_req  = 1'b1;
      host_we   = 1'b1;
      host_addr = 6'h10;
      host_din  = 4'h5;
      tick();
      host_req = 1'b0;
      check("cf_gnt", host_gnt, 1);
      core_we   = 1'b1;
      core_addr = 6'h10;
      core_din  = 4'h3;
      tick();
      core_we = 1'b0;
      #1;
      check("cf_gnt_drop", host_gnt,     0);
      check("cf_busy",     host_busy,    1);
      check("cf_no_done",  host_done,    0);
      check("cf_cnt",      conflict_cnt, 1);
      check("cf_core_val", core_dout,    4'h3);
      wait_done(n, gm, sd);
      check("cf_retry_n", n, 9);
      check("cf_retry_gmask", gm, 8'h03);
      tick();
      #1;
      check("cf_host_val", core_dout, 4'h5);

      // Repeated aborts, alternating ACC1 and ACC2, saturate the counter.
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 6'h10;
      tick();
      host_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 16; i++) begin
            #1;
            if (host_gnt) begin
               seen = 1'b1;
               break;
            end
            tick();
         end
         check("sat_slot", seen, 1);
         if (k % 2 == 1) tick();
         core_we   = 1'b1;
         core_addr = 6'h3F;
         core_din  = 4'(k);
         tick();
         core_we = 1'b0;
         if (k == 0) check("sat_cnt2", conflict_cnt, 2);
         if (k == 12) check("sat_cnt14", conflict_cnt, 14);
      end
      check("sat_cnt", conflict_cnt, 15);
      wait_done(n, gm, sd);
      check("sat_final_n", n, 8);
      check("sat_final_dout", host_dout, 4'h5);
      tick();

      // Reset during ACC1 of a host write abandons it.
      wait_phase(3'd7);
      host_req  = 1'b1;
      host_we   = 1'b1;
      host_addr = 6'h2A;
      host_din  = 4'h7;
      tick();
      host_req = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mr_gnt",  host_gnt,     0);
      check("mr_done", host_done,    0);
      check("mr_busy", host_busy,    0);
      check("mr_dout", host_dout,    0);
      check("mr_cnt",  conflict_cnt, 0);
      core_addr = 6'h2A;
      #1;
      check("mr_no_write", core_dout, 4'h9);
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (host_done) nd++;
      end
      check("mr_no_done", nd, 0);
      host_op(1'b1, 6'h2A, 4'h7, lat, gm, sd);
      check("mr_after_lat", lat, 7);
      tick();
      #1;
      check("mr_after_val", core_dout, 4'h7);

      // Core-only traffic at phase 6.
      gnt_seen = 1'b0;
      for (int m = 0; m < 24; m++) begin
         wait_phase(3'd6);
         wa[m]          = 6'($urandom_range(0, 63));
         core_addr      = wa[m];
         core_din       = 4'($urandom_range(0, 15));
         ref_mem[wa[m]] = core_din;
         core_we        = 1'b1;
         if (host_gnt) gnt_seen = 1'b1;
         tick();
         core_we = 1'b0;
         for (int i = 0; i < 7; i++) begin
            #1;
            if (host_gnt) gnt_seen = 1'b1;
            tick();
         end
      end
      check("core_no_gnt", gnt_seen, 0);
      wins = 0;
      for (int m = 0; m < 24; m++) begin
         core_addr = wa[m];
         #1;
         check("core_mem", core_dout, ref_mem[wa[m]]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
